sipo_rx: RTL and testbench

- Serial-to-parallel receiver; the receive-side counterpart of the router's parallel-to-serial transmit path.
- Samples one serial bit per qualified clock, MSB first, and assembles WIDTH-bit words.
- Presents each word on a registered valid/ready output port.
- Sits at the receive end of a router link, ahead of the CDMA despreading logic.

---
 rtl/sipo_rx.sv | 157 +++++++++++++++
 tb/tb_sipo_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// sipo_rx: serial-to-parallel receiver for the receive end of a router link.
//
// Samples one serial bit per clock with serial_valid=1, MSB first, and
// assembles WIDTH-bit words. Each finished word is presented on a registered
// valid/ready port ahead of the despreading logic.
//
// Optional build macro: PARITY_CHECK_EN
//   defined   : each word carries one trailing even-parity bit after the data
//               bits. par_err reports (XOR of data bits) ^ parity bit.
//   undefined : words are WIDTH bits and par_err is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset (asserted when 0)
//   serial_in    serial data bit, MSB of the word first
//   serial_valid serial_in is sampled this cycle
//   frame_start  with serial_valid: this bit is the first bit of a word
//   overrun_clr  clears the sticky overrun flag
//   par_out      assembled word, held while par_valid=1
//   par_valid    par_out holds an unconsumed word
//   par_ready    consumer accepts the word
//   par_err      parity error flag for the word on par_out
//   overrun      sticky: a completed word was dropped
//   sync_err     one-cycle pulse: a partial word was discarded by frame_start
//
// Handshake: a word transfers on every rising edge where par_valid and
// par_ready are both 1. While par_valid=1, par_out and par_err are held
// until that transfer. par_valid never depends combinationally on par_ready.
// A word that completes while the held word is not being taken is dropped
// and overrun is set.
module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             par_err,
  output logic             overrun,
  output logic             sync_err
);

  // Index of the final bit of a word: the parity bit when parity is enabled.
`ifdef PARITY_CHECK_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] count;

  logic             done;
  logic             take;
  logic [WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
  logic             word_err;
`endif

  always_comb begin
    // The final bit of the word is being sampled this cycle.
    done = (state == SHIFT) && serial_valid && !frame_start &&
           (count == CNT_W'(LAST));
    // The output slot is free or is being emptied on this same edge.
    take = !par_valid || par_ready;
`ifdef PARITY_CHECK_EN
    // The data bits are already in shift_reg; the current bit is the parity bit.
    word     = shift_reg;
    word_err = (^shift_reg) ^ serial_in;
`else
    // The current bit is the LSB and completes the word.
    word = WIDTH'({shift_reg, serial_in});
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err   <= 1'b0;
`endif
    end else begin
      sync_err <= 1'b0;

      case (state)
        IDLE: begin
          if (serial_valid && frame_start) begin
            shift_reg <= WIDTH'(serial_in);
            count     <= CNT_W'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (serial_valid) begin
            if (frame_start) begin
              // A non-zero count means a partial word is being thrown away.
              if (count != '0) sync_err <= 1'b1;
              shift_reg <= WIDTH'(serial_in);
              count     <= CNT_W'(1);
            end else if (done) begin
              // Stay in SHIFT so the next word streams in without frame_start.
              count <= '0;
`ifndef PARITY_CHECK_EN
              shift_reg <= word;
`endif
            end else begin
              shift_reg <= WIDTH'({shift_reg, serial_in});
              count     <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Output slot: load a completed word if there is room, else drop it.
      if (done && take) begin
        par_out   <= word;
        par_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        par_err   <= word_err;
`endif
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
        par_err   <= 1'b0;
`endif
      end

      // A drop on the same edge as overrun_clr keeps the flag set.
      if (done && !take) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifndef PARITY_CHECK_EN
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: self-checking bench for sipo_rx. Runs directed word scenarios
// followed by random serial traffic. A word-level reference model (bit
// queue per word, one-entry output slot) predicts every output each cycle,
// and a scoreboard queue holds the words expected at the handshake.
// Builds with or without PARITY_CHECK_EN.
module tb_sipo_rx;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
`ifdef PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = WIDTH + PAR;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sin = 1'b0;
  logic             sv = 1'b0;
  logic             fs = 1'b0;
  logic             oclr = 1'b0;
  logic             rdy = 1'b0;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_err;
  logic             overrun;
  logic             sync_err;

  sipo_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .serial_in    (sin),
    .serial_valid (sv),
    .frame_start  (fs),
    .overrun_clr  (oclr),
    .par_out      (par_out),
    .par_valid    (par_valid),
    .par_ready    (rdy),
    .par_err      (par_err),
    .overrun      (overrun),
    .sync_err     (sync_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               cur_q[$];   // bits of the word in progress, in arrival order
  bit               in_word = 0; // a framed word has been started since reset
  bit               m_valid = 0;
  logic [WIDTH-1:0] m_out = '0;
  bit               m_err = 0;
  bit               m_ovr = 0;
  bit               m_sync = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               sync_seen = 0;

  task automatic model_edge();
    bit               consumed;
    bit               completed;
    logic [WIDTH-1:0] val;
    bit               err;
    completed = 0;
    val = '0;
    err = 0;
    if (!rst_n) begin
      cur_q.delete();
      exp_q.delete();
      in_word = 0;
      m_valid = 0;
      m_out = '0;
      m_err = 0;
      m_ovr = 0;
      m_sync = 0;
    end else begin
      consumed = m_valid && rdy;
      m_sync = 0;
      if (sv) begin
        if (fs) begin
          if (cur_q.size() != 0) m_sync = 1;
          cur_q.delete();
          cur_q.push_back(sin);
          in_word = 1;
        end else if (in_word) begin
          cur_q.push_back(sin);
          if (cur_q.size() == NB) begin
            completed = 1;
            for (int i = 0; i < WIDTH; i++) val = (val << 1) | WIDTH'(cur_q[i]);
            if (PAR != 0) foreach (cur_q[i]) err = err ^ cur_q[i];
            cur_q.delete();
          end
        end
      end
      if (completed && (!m_valid || consumed)) begin
        m_valid = 1;
        m_out = val;
        m_err = err;
        exp_q.push_back(val);
      end else if (consumed) begin
        m_valid = 0;
        m_err = 0;
      end
      if (completed && m_valid && !consumed && (m_out != val || 1'b1) && !(!m_valid)) begin
        // handled below
      end
      if (completed && !(exp_q.size() != 0 && exp_q[$] == val && m_out == val && m_valid && (consumed || 1'b0)) && 1'b0) begin
      end
    end
  endtask

  // Drop/overrun is decided from the slot state before the edge, so it is
  // evaluated separately with the pre-edge values passed in.
  task automatic model_overrun(input bit was_valid, input bit was_ready, input bit completed);
    if (rst_n) begin
      if (completed && was_valid && !was_ready) m_ovr = 1;
      else if (oclr) m_ovr = 0;
    end
  endtask

  // One clock cycle: scoreboard the handshake, update the model on the
  // edge, then compare outputs 1 time unit later.
  task automatic step();
    bit pre_valid;
    bit will_complete;
    pre_valid = m_valid;
    will_complete = rst_n && sv && !fs && in_word && (cur_q.size() == NB - 1);
    if (rst_n && par_valid === 1'b1 && rdy) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(par_out), 32'hdead);
      else check("sb_word", 32'(par_out), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    model_overrun(pre_valid, rdy, will_complete);
    model_edge();
    #1;
    check("par_valid", 32'(par_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("sync_err", 32'(sync_err), 32'(m_sync));
    check("par_err", 32'(par_err), 32'(m_err));
    if (m_valid) check("par_out", 32'(par_out), 32'(m_out));
    if (sync_err === 1'b1) sync_seen++;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] frame_bits(input logic [WIDTH-1:0] w, input bit bad);
    logic p;
    p = (^w) ^ bad;
    if (PAR != 0) return 8'({w, p});
    return 8'(w);
  endfunction

  task automatic send_bits(input logic [7:0] b, input int n, input bit framed, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sv = 0;
          fs = 0;
          step();
        end
      end
      sv = 1;
      sin = b[i];
      fs = framed && (i == n - 1);
      step();
    end
    sv = 0;
    fs = 0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit framed, input bit gaps);
    send_bits(frame_bits(w, 1'b0), NB, framed, gaps);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;

    // Reset values.
    rst_n = 0;
    repeat (2) step();
    check("rst_par_out", 32'(par_out), 32'h0);
    check("rst_par_valid", 32'(par_valid), 32'h0);
    check("rst_par_err", 32'(par_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_sync_err", 32'(sync_err), 32'h0);
    rst_n = 1;

    // Basic word 1,0,1,1: visible one cycle after the last bit, for one cycle.
    rdy = 1;
    send_word(4'hB, 1, 0);
    check("basic_out", 32'(par_out), 32'hB);
    check("basic_valid", 32'(par_valid), 32'h1);
    step();
    check("basic_valid_fall", 32'(par_valid), 32'h0);

    // Stalls and streaming without a second frame_start.
    s0 = sync_seen;
    send_word(4'hC, 1, 1);
    check("stream_first", 32'(par_out), 32'hC);
    send_word(4'h6, 0, 0);
    check("stream_second", 32'(par_out), 32'h6);
    check("stream_no_sync", 32'(sync_seen - s0), 32'h0);
    step();

    // Overrun: the second word is dropped while the first is held.
    rdy = 0;
    send_word(4'hA, 1, 0);
    send_word(4'h5, 0, 0);
    check("ovr_hold", 32'(par_out), 32'hA);
    check("ovr_set", 32'(overrun), 32'h1);
    oclr = 1;
    step();
    oclr = 0;
    check("ovr_clr", 32'(overrun), 32'h0);
    check("ovr_hold2", 32'(par_out), 32'hA);
    check("ovr_valid", 32'(par_valid), 32'h1);
    rdy = 1;
    step();
    check("ovr_drain", 32'(par_valid), 32'h0);

    // Resync: two bits then a new frame_start.
    s0 = sync_seen;
    send_bits(8'b10, 2, 1, 0);
    send_word(4'h7, 1, 0);
    check("resync_pulse", 32'(sync_seen - s0), 32'h1);
    check("resync_out", 32'(par_out), 32'h7);
    step();

    // Reset mid-word leaves no residue.
    send_bits(8'b101, 3, 1, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    check("midrst_valid", 32'(par_valid), 32'h0);
    send_word(4'h9, 1, 0);
    check("midrst_out", 32'(par_out), 32'h9);
    step();

`ifdef PARITY_CHECK_EN
    send_bits(frame_bits(4'hB, 1'b0), NB, 1, 0);
    check("par_good_out", 32'(par_out), 32'hB);
    check("par_good_err", 32'(par_err), 32'h0);
    step();
    send_bits(frame_bits(4'hB, 1'b1), NB, 1, 0);
    check("par_bad_out", 32'(par_out), 32'hB);
    check("par_bad_err", 32'(par_err), 32'h1);
    step();
    check("par_err_clr", 32'(par_err), 32'h0);
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      sv    = ($urandom_range(0, 3) != 0);
      fs    = ($urandom_range(0, 11) == 0);
      sin   = 1'($urandom_range(0, 1));
      rdy   = ($urandom_range(0, 2) != 0);
      oclr  = ($urandom_range(0, 9) == 0);
      step();
    end

    // Drain and confirm every expected word was delivered.
    rst_n = 1;
    sv = 0;
    fs = 0;
    oclr = 0;
    rdy = 1;
    repeat (3) step();
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
